pc_gen: RTL and testbench

Parametrised program-counter generator for the single-cycle core's fetch stage. It replaces the fixed two-way "PC+4 or PC+imm" counter with several redirect sources, a stall input and misalignment trapping. It also holds a small circular return-address stack (RAS) that serves call/return. It drives the instruction-memory address and supplies `pc_plus4` to the register-file write-back mux.

---
 rtl/pc_pkg.sv | 17 +
 rtl/ras.sv | 68 ++++++
 rtl/pc_gen.sv | 104 ++++++++++
 tb/tb_pc_gen.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and default vectors for the fetch-stage program-counter generator.
package pc_pkg;

  typedef enum logic [2:0] {
    SEQ  = 3'd0,
    REL  = 3'd1,
    REG  = 3'd2,
    TRAP = 3'd3,
    RET  = 3'd4
  } pc_sel_t;

  localparam int unsigned XLEN_DEF         = 32;
  localparam int unsigned RAS_DEPTH_DEF    = 4;
  localparam logic [31:0] RESET_VECTOR_DEF = 32'hBFC0_0000;
  localparam logic [31:0] TRAP_VECTOR_DEF  = 32'hBFC0_0100;

endpackage

// File: rtl/ras.sv
// Circular return-address stack: wrapping top pointer with saturating count;
// a push into a full stack silently overwrites the oldest entry.
module ras #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top_data,
  output logic            empty,
  output logic            full
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  logic [XLEN-1:0]  mem [RAS_DEPTH];
  logic [PTR_W-1:0] top_q;
  logic [PTR_W-1:0] top_d;
  logic [PTR_W-1:0] wr_idx;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign top_data = mem[top_q];

  // Push+pop together replaces the top entry in place.
  always_comb begin
    top_d   = top_q;
    count_d = count_q;
    wr_idx  = top_q + PTR_W'(1);
    if (push && pop) begin
      wr_idx = top_q;
    end else if (push) begin
      top_d = top_q + PTR_W'(1);
      if (count_q != CNT_W'(RAS_DEPTH)) begin
        count_d = count_q + CNT_W'(1);
      end
    end else if (pop && (count_q != CNT_W'(0))) begin
      top_d   = top_q - PTR_W'(1);
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      top_q   <= '0;
      count_q <= '0;
      empty   <= 1'b1;
      full    <= 1'b0;
    end else begin
      top_q   <= top_d;
      count_q <= count_d;
      empty   <= (count_d == CNT_W'(0));
      full    <= (count_d == CNT_W'(RAS_DEPTH));
    end
  end

  // Entry storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage PC generator: next-PC mux with alignment trapping, PC and flag
// registers, and a return-address stack for call/return.
module pc_gen
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN         = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEF),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(TRAP_VECTOR_DEF),
  parameter int unsigned     RAS_DEPTH    = RAS_DEPTH_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic [2:0]      pc_sel,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1,
  input  logic            is_call,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            misaligned,
  output logic            ras_underflow,
  output logic            ras_empty,
  output logic            ras_full
);

  logic [XLEN-1:0] target_c;
  logic [XLEN-1:0] next_pc_c;
  logic [XLEN-1:0] ras_top;
  logic            check_align_c;
  logic            call_ok_c;
  logic            underflow_c;
  logic            misalign_c;
  logic            pop_c;
  logic            ras_push;
  logic            ras_pop;

  assign pc_plus4 = pc + XLEN'(4);

  // Target selection; reserved codes fall through to sequential.
  always_comb begin
    target_c      = pc_plus4;
    check_align_c = 1'b0;
    call_ok_c     = 1'b0;
    underflow_c   = 1'b0;
    pop_c         = 1'b0;
    case (pc_sel)
      REL: begin
        target_c      = pc + imm;
        check_align_c = 1'b1;
        call_ok_c     = 1'b1;
      end
      REG: begin
        target_c      = (rs1 + imm) & ~XLEN'(1);
        check_align_c = 1'b1;
        call_ok_c     = 1'b1;
      end
      TRAP: target_c = TRAP_VECTOR;
      RET: begin
        if (ras_empty) begin
          target_c    = TRAP_VECTOR;
          underflow_c = 1'b1;
        end else begin
          target_c      = ras_top;
          check_align_c = 1'b1;
          call_ok_c     = 1'b1;
          pop_c         = 1'b1;
        end
      end
      default: target_c = pc_plus4;
    endcase
    misalign_c = check_align_c && (target_c[1:0] != 2'b00);
    next_pc_c  = (misalign_c || underflow_c) ? TRAP_VECTOR : target_c;
  end

  assign ras_push = is_call && call_ok_c && !stall;
  assign ras_pop  = pop_c && !stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc            <= RESET_VECTOR;
      misaligned    <= 1'b0;
      ras_underflow <= 1'b0;
    end else if (!stall) begin
      pc            <= next_pc_c;
      misaligned    <= misalign_c;
      ras_underflow <= underflow_c;
    end
  end

  ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_plus4),
    .top_data  (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios pinned to literal values
// plus randomized traffic against a queue-based behavioural model.
module tb_pc_gen;

  localparam logic [31:0] RSTV  = 32'hBFC0_0000;
  localparam logic [31:0] TRAPV = 32'hBFC0_0100;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [2:0]  pc_sel;
  logic [31:0] imm;
  logic [31:0] rs1;
  logic        is_call;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        misaligned;
  logic        ras_underflow;
  logic        ras_empty;
  logic        ras_full;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_pc;
  logic        m_mis;
  logic        m_und;
  logic [31:0] m_ras [$];

  pc_gen dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .pc_sel        (pc_sel),
    .imm           (imm),
    .rs1           (rs1),
    .is_call       (is_call),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .misaligned    (misaligned),
    .ras_underflow (ras_underflow),
    .ras_empty     (ras_empty),
    .ras_full      (ras_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc  = RSTV;
    m_mis = 1'b0;
    m_und = 1'b0;
    m_ras.delete();
  endtask

  // What one unstalled clock edge must do, from the architectural rules.
  task automatic model_step();
    logic [31:0] tgt;
    logic        align_chk;
    logic        call_ok;
    logic        und;
    if (stall) return;
    tgt       = m_pc + 32'd4;
    align_chk = 1'b0;
    call_ok   = 1'b0;
    und       = 1'b0;
    case (pc_sel)
      3'd1: begin tgt = m_pc + imm; align_chk = 1'b1; call_ok = 1'b1; end
      3'd2: begin tgt = (rs1 + imm) & 32'hFFFF_FFFE; align_chk = 1'b1; call_ok = 1'b1; end
      3'd3: tgt = TRAPV;
      3'd4: begin
        if (m_ras.size() == 0) begin
          und = 1'b1;
        end else begin
          tgt       = m_ras[m_ras.size()-1];
          align_chk = 1'b1;
          if (is_call) m_ras[m_ras.size()-1] = m_pc + 32'd4;
          else void'(m_ras.pop_back());
        end
      end
      default: ;
    endcase
    if (call_ok && is_call) begin
      m_ras.push_back(m_pc + 32'd4);
      if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
    end
    m_mis = align_chk && (tgt[1:0] != 2'b00);
    m_und = und;
    m_pc  = (m_mis || und) ? TRAPV : tgt;
  endtask

  task automatic check_all();
    chk("pc", pc, m_pc);
    chk("pc_plus4", pc_plus4, m_pc + 32'd4);
    chk("misaligned", 32'(misaligned), 32'(m_mis));
    chk("ras_underflow", 32'(ras_underflow), 32'(m_und));
    chk("ras_empty", 32'(ras_empty), 32'(m_ras.size() == 0));
    chk("ras_full", 32'(ras_full), 32'(m_ras.size() == DEPTH));
  endtask

  // Called at a falling edge; applies inputs for the next rising edge.
  task automatic tick(input logic [2:0] sel, input logic [31:0] im, input logic [31:0] r,
                      input logic call, input logic stl);
    pc_sel  = sel;
    imm     = im;
    rs1     = r;
    is_call = call;
    stall   = stl;
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check_all();
    rst = 1'b1;
  endtask

  initial begin
    logic [31:0] im;
    logic [31:0] r;
    logic [2:0]  sel;
    rst = 1'b1; stall = 1'b0; pc_sel = 3'd0; imm = '0; rs1 = '0; is_call = 1'b0;
    #1;
    do_reset();
    chk("reset_pc", pc, 32'hBFC0_0000);
    chk("reset_empty", 32'(ras_empty), 32'd1);

    // Sequential fetch.
    for (int i = 1; i <= 5; i++) begin
      tick(3'd0, 0, 0, 1'b0, 1'b0);
      chk("seq_pc", pc, RSTV + 32'(4 * i));
    end
    chk("seq_empty", 32'(ras_empty), 32'd1);

    // Relative and register-indirect jumps.
    do_reset();
    for (int i = 0; i < 4; i++) tick(3'd0, 0, 0, 1'b0, 1'b0);
    chk("at_10", pc, 32'hBFC0_0010);
    tick(3'd1, -32'sd8, 0, 1'b0, 1'b0);
    chk("rel_neg8", pc, 32'hBFC0_0008);
    tick(3'd2, 32'd0, 32'hBFC0_0101, 1'b0, 1'b0);
    chk("reg_clr_lsb", pc, 32'hBFC0_0100);
    chk("reg_no_mis", 32'(misaligned), 32'd0);

    // Single call and return.
    do_reset();
    tick(3'd1, 32'h40, 0, 1'b1, 1'b0);
    chk("call_pc", pc, 32'hBFC0_0040);
    chk("call_nonempty", 32'(ras_empty), 32'd0);
    tick(3'd4, 0, 0, 1'b0, 1'b0);
    chk("ret_pc", pc, 32'hBFC0_0004);
    chk("ret_empty", 32'(ras_empty), 32'd1);

    // Overflowing the stack: oldest return address is lost.
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      tick(3'd1, 32'h40, 0, 1'b1, 1'b0);
      chk("deep_call_pc", pc, RSTV + 32'(64 * i));
      if (i == 4) chk("full_after_4", 32'(ras_full), 32'd1);
    end
    tick(3'd4, 0, 0, 1'b0, 1'b0); chk("ret1", pc, 32'hBFC0_0104);
    tick(3'd4, 0, 0, 1'b0, 1'b0); chk("ret2", pc, 32'hBFC0_00C4);
    tick(3'd4, 0, 0, 1'b0, 1'b0); chk("ret3", pc, 32'hBFC0_0084);
    tick(3'd4, 0, 0, 1'b0, 1'b0); chk("ret4", pc, 32'hBFC0_0044);
    tick(3'd4, 0, 0, 1'b0, 1'b0);
    chk("ret5_trap", pc, TRAPV);
    chk("ret5_underflow", 32'(ras_underflow), 32'd1);
    tick(3'd0, 0, 0, 1'b0, 1'b0);
    chk("underflow_pulse_end", 32'(ras_underflow), 32'd0);

    // Misaligned relative target.
    do_reset();
    tick(3'd1, 32'd2, 0, 1'b0, 1'b0);
    chk("mis_trap", pc, TRAPV);
    chk("mis_flag", 32'(misaligned), 32'd1);
    tick(3'd0, 0, 0, 1'b0, 1'b0);
    chk("mis_after", pc, 32'hBFC0_0104);
    chk("mis_pulse_end", 32'(misaligned), 32'd0);

    // Stall held across a return.
    do_reset();
    tick(3'd1, 32'h40, 0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(3'd4, 0, 0, 1'b0, 1'b1);
      chk("stall_pc", pc, 32'hBFC0_0040);
      chk("stall_ras", 32'(ras_empty), 32'd0);
    end
    tick(3'd4, 0, 0, 1'b0, 1'b0);
    chk("post_stall_ret", pc, 32'hBFC0_0004);

    // Asynchronous reset between edges with two stacked entries.
    do_reset();
    tick(3'd1, 32'h40, 0, 1'b1, 1'b0);
    tick(3'd1, 32'h40, 0, 1'b1, 1'b0);
    stall = 1'b1;
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk("async_pc", pc, 32'hBFC0_0000);
    chk("async_empty", 32'(ras_empty), 32'd1);
    check_all();
    @(negedge clk);
    rst = 1'b1;

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        sel = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 3) == 0) sel = 3'd4;
        if ($urandom_range(0, 4) == 0) im = $urandom;
        else im = (32'($urandom_range(0, 511)) - 32'd256) & 32'hFFFF_FFFC;
        if ($urandom_range(0, 3) == 0) r = $urandom;
        else r = m_pc + 32'($urandom_range(0, 255));
        tick(sel, im, r, 1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 9) < 2));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
